// File: rtl/sopc_pio_pkg.sv
// Shared constants for the Avalon-MM PIO slaves: register map and edge/irq mode encodings.
package sopc_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/sopc_pio_sync_edge.sv
// Two-flop input synchroniser plus a one-cycle history register that yields a per-bit
// edge pulse vector of the kind selected by EDGE_TYPE.
module sopc_pio_sync_edge
  import sopc_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign data_in = sync2_q;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse = ~sync2_q & prev_q;
      EDGE_ANY:  edge_pulse = sync2_q ^ prev_q;
      default:   edge_pulse = sync2_q & ~prev_q;
    endcase
  end

endmodule

// File: rtl/sopc_data32_in.sv
// Avalon-MM input PIO: synchronised data register, sticky edge capture and maskable irq.
// Define SOPC_DATA_IN_BITCLR_EN for write-1-to-clear edge_capture; otherwise any write clears all.
module sopc_data32_in
  import sopc_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISE,
  parameter int IRQ_TYPE  = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] clr_bits;
  logic             irq_q, irq_d;
  logic             wr_en;

  sopc_pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .data_in    (data_in),
    .edge_pulse (edge_pulse)
  );

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGE) begin
`ifdef SOPC_DATA_IN_BITCLR_EN
      clr_bits = writedata[WIDTH-1:0];
`else
      clr_bits = '1;
`endif
    end
  end

  // New edges are OR-ed in after the clear so a same-cycle edge is never lost.
  always_comb begin
    irq_mask_d     = irq_mask_q;
    edge_capture_d = (edge_capture_q & ~clr_bits) | edge_pulse;
    if (wr_en && address == ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (IRQ_TYPE == IRQ_EDGE) begin
      irq_d = |(edge_capture_q & irq_mask_q);
    end else begin
      irq_d = |(data_in & irq_mask_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      irq_q          <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = data_in;
      ADDR_DIR:  readdata            = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture_q;
      default:   readdata            = '0;
    endcase
  end

endmodule
